dct_quantizer: RTL
==================

// Module: dct_quantizer
// PURPOSE
//  Stage directly downstream of the 2-D DCT. Consumes the 12-bit signed coefficient stream, 64 per 8x8 block,
//  one per En_In cycle. Divides each coefficient by its JPEG quantisation step using a reciprocal-multiply ROM.
//  Emits 12-bit signed quantised values toward the zig-zag/entropy stages. Fully pipelined, no backpressure.
// PARAMETERS
//  IN_W     12  coefficient input width (signed)
//  OUT_W    12  quantised output width (signed)
//  RECIP_W  17  reciprocal width, unsigned; R[k]=round(65536/Q[k]); Q=1 gives 65536
//  Q_SCALE  50  JPEG quality; tables are the Annex K tables scaled per IJG, each Q[k] clamped to 1..255
// PORTS
//  Clock       in   1      rising-edge clock
//  Reset_n     in   1      asynchronous active-low reset
//  En_In       in   1      In_Data valid this cycle
//  In_Data     in   IN_W   signed DCT coefficient; block index k=0..63 in DCT output order (row-major u*8+v)
//  En_Out      out  1      Out_Data valid this cycle
//  Out_Data    out  OUT_W  signed quantised coefficient
//  Blk_Last    out  1      high with En_Out on the quantised value of index 63
//  Tbl_Sel     in   1      only with QUANT_CHROMA_EN: 0 luma table, 1 chroma table
// BEHAVIOUR
//  Reset: En_Out=0, Out_Data=0, Blk_Last=0; index counter=0; all pipeline valid bits cleared.
//  Index counter k (6 bit): increments on each En_In; wraps 63->0; holds when En_In=0.
//   Gaps mid-block are legal and do not reset k.
//  Pipeline: latency exactly 3 cycles, one result per cycle, input accepted every cycle.
//   S1: register sign s, magnitude m=|In| (m<=2048), R[k], last=(k==63).
//   S2: p = m*R[k], unsigned, 29 bits.
//   S3: q = (p + 2^15) >> 16, i.e. round half away from zero in signed terms.
//       q saturates to 2^(OUT_W-1)-1. Out_Data = s ? -q : q.
//  En_Out = En_In delayed 3 cycles. Blk_Last = last flag delayed with the data.
//  Out_Data holds its last value while En_Out=0; it is not zeroed.
//  Zero input gives zero output; a negative zero result is emitted as 0.
//  Reset asserted mid-block discards in-flight data; the next En_In is index 0.
//  Reset release mid-stream is not a supported upstream pattern; upstream restarts on a block boundary.
//  There is no overflow or stall condition; the downstream must accept every En_Out beat.
// CONFIGURATION
//  QUANT_CHROMA_EN defined:
//   Adds the Tbl_Sel port and a second ROM holding the chroma table.
//   Tbl_Sel is sampled on the En_In beat with k==0 and held for the whole block.
//   Changing Tbl_Sel mid-block has no effect until the next k==0.
//  QUANT_CHROMA_EN undefined: luma table only; Tbl_Sel port absent; behaviour otherwise identical.
// TESTING
//  1 Reset then 64 beats In_Data=0 -> 64 beats Out_Data=0, En_Out 3 cycles after each En_In.
//    Blk_Last only on the 64th beat.
//  2 Luma Q50, k=0 (Q=16, R=4096): In=100 -> 6; In=-24 -> -2 (half away from zero); In=8 -> 1; In=7 -> 0.
//  3 k=0, In=-2048 with Q=1 table override (R=65536) -> -2048 clamps magnitude to 2047 -> Out=-2047.
//  4 Random En_In gaps across 3 blocks -> index stays aligned; each output equals the golden model.
//    Blk_Last fires exactly once per 64 beats.
//  5 Assert Reset_n at k=30 with 3 beats in flight -> En_Out=0 immediately and no stale beats emerge.
//    The next input uses the k=0 table.
//  6 (QUANT_CHROMA_EN) Tbl_Sel=1 at k=0, In=170 at k=0 (chroma Q=17) -> 10.
//    Toggling Tbl_Sel at k=5 has no effect until the next block.

Source files
------------

// File: rtl/dct_quantizer_if.sv
// dct_quantizer_if: coefficient stream into and quantised stream out of dct_quantizer
//   En_In/In_Data          upstream beat (master drives)
//   En_Out/Out_Data/Blk_Last  quantised beat (slave drives)
interface dct_quantizer_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 12
);
  logic             En_In;
  logic [IN_W-1:0]  In_Data;
  logic             En_Out;
  logic [OUT_W-1:0] Out_Data;
  logic             Blk_Last;
  modport master (output En_In, In_Data, input En_Out, Out_Data, Blk_Last);
  modport slave  (input En_In, In_Data, output En_Out, Out_Data, Blk_Last);
endinterface

// File: rtl/dct_quantizer.sv
// dct_quantizer: divides 8x8 DCT coefficients by JPEG quant steps via reciprocal multiply, 3-cycle pipeline
//   Clock, Reset_n (async active-low), q_if (slave: En_In/In_Data in, En_Out/Out_Data/Blk_Last out)
//   Tbl_Sel present only when QUANT_CHROMA_EN is defined (0 luma, 1 chroma, sampled at k==0)
//   Data buses carry two's complement values.
module dct_quantizer #(
  parameter int IN_W    = 12,
  parameter int OUT_W   = 12,
  parameter int RECIP_W = 17,
  parameter int Q_SCALE = 50
) (
  input logic Clock,
  input logic Reset_n,
`ifdef QUANT_CHROMA_EN
  input logic Tbl_Sel,
`endif
  dct_quantizer_if.slave q_if
);
  localparam int PW   = IN_W + RECIP_W;
  localparam int RW   = PW + 1;
  localparam int QW   = RW - 16;
  localparam int OMAX = 2 ** (OUT_W - 1) - 1;
  localparam logic [511:0] LUMA_B = {
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24, 8'd40, 8'd51, 8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26, 8'd58, 8'd60, 8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40, 8'd57, 8'd69, 8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51, 8'd87, 8'd80, 8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68, 8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81, 8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99};
  // IJG quality scaling, clamp to 1..255, then R = round(65536/Q); entry k sits at bits [k*RECIP_W +: RECIP_W]
  function automatic logic [64*RECIP_W-1:0] build_rom(input logic [511:0] base);
    logic [64*RECIP_W-1:0] r;
    int scale, q;
    scale = Q_SCALE < 50 ? 5000 / Q_SCALE : 200 - 2 * Q_SCALE;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      q = (int'(base[(63-i)*8 +: 8]) * scale + 50) / 100;
      q = q < 1 ? 1 : (q > 255 ? 255 : q);
      r[i*RECIP_W +: RECIP_W] = RECIP_W'((65536 + q / 2) / q);
    end
    return r;
  endfunction
  localparam logic [64*RECIP_W-1:0] LUMA_R = build_rom(LUMA_B);
  logic [5:0] k_q, k_d;
  logic [RECIP_W-1:0] r_sel;
`ifdef QUANT_CHROMA_EN
  localparam logic [511:0] CHROMA_B = {
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    {32{8'd99}}};
  localparam logic [64*RECIP_W-1:0] CHROMA_R = build_rom(CHROMA_B);
  logic tbl_q, tbl_d, sel;
  // the k==0 beat uses the live select; later beats of the block use the latched one
  always_comb begin
    sel   = (k_q == 6'd0) ? Tbl_Sel : tbl_q;
    tbl_d = q_if.En_In ? sel : tbl_q;
    r_sel = sel ? CHROMA_R[k_q*RECIP_W +: RECIP_W] : LUMA_R[k_q*RECIP_W +: RECIP_W];
  end
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) tbl_q <= 1'b0;
    else tbl_q <= tbl_d;
`else
  assign r_sel = LUMA_R[k_q*RECIP_W +: RECIP_W];
`endif
  logic s1_v_q, s1_v_d, s1_s_q, s1_s_d, s1_last_q, s1_last_d;
  logic [IN_W-1:0] s1_m_q, s1_m_d;
  logic [RECIP_W-1:0] s1_r_q, s1_r_d;
  logic s2_v_q, s2_v_d, s2_s_q, s2_s_d, s2_last_q, s2_last_d;
  logic [PW-1:0] s2_p_q, s2_p_d;
  logic en_out_q, en_out_d, blk_last_q, blk_last_d;
  logic [OUT_W-1:0] out_q, out_d, qs;
  logic [QW-1:0] q;
  always_comb begin
    k_d        = q_if.En_In ? k_q + 6'd1 : k_q;
    s1_v_d     = q_if.En_In;
    s1_s_d     = q_if.In_Data[IN_W-1];
    s1_m_d     = s1_s_d ? -q_if.In_Data : q_if.In_Data;
    s1_r_d     = r_sel;
    s1_last_d  = &k_q;
    s2_v_d     = s1_v_q;
    s2_s_d     = s1_s_q;
    s2_last_d  = s1_last_q;
    s2_p_d     = PW'(s1_m_q) * PW'(s1_r_q);
    q          = QW'((RW'(s2_p_q) + RW'(32768)) >> 16);
    qs         = (q > QW'(OMAX)) ? OUT_W'(OMAX) : q[OUT_W-1:0];
    en_out_d   = s2_v_q;
    blk_last_d = s2_v_q & s2_last_q;
    out_d      = s2_v_q ? (s2_s_q ? -qs : qs) : out_q;
  end
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      k_q        <= '0;
      s1_v_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_m_q     <= '0;
      s1_r_q     <= '0;
      s1_last_q  <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_s_q     <= 1'b0;
      s2_p_q     <= '0;
      s2_last_q  <= 1'b0;
      en_out_q   <= 1'b0;
      blk_last_q <= 1'b0;
      out_q      <= '0;
    end else begin
      k_q        <= k_d;
      s1_v_q     <= s1_v_d;
      s1_s_q     <= s1_s_d;
      s1_m_q     <= s1_m_d;
      s1_r_q     <= s1_r_d;
      s1_last_q  <= s1_last_d;
      s2_v_q     <= s2_v_d;
      s2_s_q     <= s2_s_d;
      s2_p_q     <= s2_p_d;
      s2_last_q  <= s2_last_d;
      en_out_q   <= en_out_d;
      blk_last_q <= blk_last_d;
      out_q      <= out_d;
    end
  assign q_if.En_Out   = en_out_q;
  assign q_if.Blk_Last = blk_last_q;
  assign q_if.Out_Data = out_q;
endmodule
